smpc_port_scan: RTL and testbench
=================================

# smpc_port_scan

Peripheral-port scan sequencer for the SMPC. On request (INTBACK peripheral phase) it drives the TH/TR select lines of both controller ports through four select phases, samples the returned data nibbles after a programmable settle time, identifies standard digital pads and publishes one 16-bit button word per port. The SMPC command engine owns the request/abort handshake and copies the published words into OREG.

## Interface
Parameters:
- SETTLE, 8, CE ticks between driving a select code and sampling the nibble; legal range 1..255.

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset; synchronous, active-high.
- CE  in  1  clock enable; all sequencing advances only on CLK edges with CE=1, except ABORT and RST.
- REQ  in  1  start scan; sampled in IDLE on a CE tick.
- ABORT  in  1  cancel scan (INTBACK break); acts on any CLK edge.
- PORT_EN  in  2  per-port enable, bit0 = port 1, bit1 = port 2; latched at REQ acceptance.
- P1I  in  7  port 1 pins; [3:0] data nibble.
- P2I  in  7  port 2 pins; same layout.
- P1O  out  7  port 1 drive values; [6]=TH, [5]=TR, [4:0]=0.
- P1OE  out  7  port 1 output enables; [6:5]=PORT_EN latched bit, [4:0]=0.
- P2O, P2OE  out  7  same for port 2.
- PAD1, PAD2  out  16  published button words, active-low.
- PRES  out  2  per-port standard pad present.
- BUSY  out  1  high in any state other than IDLE.
- DONE  out  1  one-CLK pulse when results are published.

## Operation
- States: IDLE, SETTLE, FINISH. Phase counter PH (2 bits), settle counter CNT (8 bits), 16-bit shift register per port.
- Select code per phase: {TH,TR} = PH (phase0=00, 1=01, 2=10, 3=11). IDLE, FINISH and reset drive {TH,TR}=11.
- IDLE: on CE tick with REQ=1 and ABORT=0: latch PORT_EN, PH<=0, drive select 00 on both ports, CNT<=SETTLE-1, go SETTLE. REQ while BUSY is ignored (no queueing).
- SETTLE, per CE tick: if CNT!=0, CNT<=CNT-1; else shift {Px_I[3:0]} into the shift register for each port (phase0 lands in [15:12], phase3 in [3:0]). If PH=3 go FINISH; else PH<=PH+1, drive the new select code, CNT<=SETTLE-1.
- FINISH, on CE tick: per port, present = latched enable AND phase3 nibble[2:0]==3'b100. Present port: PADx<=shift value, PRES bit<=1. Absent or disabled port: PADx<=16'hFFFF, PRES bit<=0. Drive select 11, DONE<=1 for exactly one CLK, go IDLE.
- Disabled ports are still stepped (select lines toggle) but OE=0 on them, so nothing is driven.
- ABORT: from any state, next CLK edge → IDLE, select 11, BUSY=0, no DONE, PAD/PRES keep previous values. ABORT with REQ in IDLE: ABORT wins; no scan starts.
- RST overrides everything including ABORT.

## Timing
- Reset values: state IDLE, PAD1=PAD2=16'hFFFF, PRES=2'b00, BUSY=0, DONE=0, P1O=P2O=7'h60, P1OE=P2OE=7'h00, PH=0, CNT=0.
- REQ accepted at CE tick T0 → BUSY high from the edge at T0. Phase k sampled at CE tick T0+(k+1)·SETTLE. FINISH at tick T0+4·SETTLE+1; PAD/PRES updated and DONE high on that edge, DONE low on the next CLK edge regardless of CE.
- With CE tied high, REQ-to-DONE = 4·SETTLE+1 CLK cycles; with SETTLE=8: 33 cycles.
- Select code changes exactly on the edge that samples the previous nibble; sampled values are those present on that edge (no additional input sync stage; inputs arrive pre-synchronized).
- Zero CE ticks: state, counters and outputs hold indefinitely; DONE never stretches past one CLK.
- Counters never wrap: CNT reloads before underflow, PH leaves SETTLE at 3.

## Test plan
- Reset: assert RST 2 cycles → PAD1=PAD2=FFFF, PRES=00, P1O=P2O=60, OEs=00, BUSY=0, DONE=0.
- Standard pad on port 1, nibbles per phase 00→A, 01→5, 10→C, 11→4; PORT_EN=01, SETTLE=8, CE=1 → DONE at cycle 33 after REQ, PAD1=A5C4, PRES=01, PAD2=FFFF, P1O TH/TR sequence 00,01,10,11 each held 8 cycles then 11.
- Both ports, port 2 phase3 nibble=7 (ID 111): PORT_EN=11 → PRES=01, PAD2=FFFF, PAD1 valid.
- ABORT asserted 10 cycles after REQ → BUSY low next cycle, no DONE, PAD/PRES unchanged from previous scan, select lines back to 11; following REQ scans normally.
- CE pulsed every 3rd cycle, SETTLE=2 → DONE 9 CE ticks after the accepting tick, DONE width exactly 1 CLK; second REQ during BUSY ignored (only one DONE).
- RST mid-scan (PH=2) → all outputs to reset values next cycle, no DONE; ABORT+REQ same IDLE cycle → no scan.

Source files
------------

// File: rtl/smpc_port_scan.sv
// smpc_port_scan: SMPC peripheral-port scan sequencer.
//
// When a scan is requested, the TH/TR select lines of both controller ports
// step through the four select codes 00, 01, 10 and 11. After each code has
// been driven for SETTLE CE ticks, the returned data nibble is sampled. A port
// whose phase-3 nibble ID bits [2:0] read 3'b100 is reported as a standard
// digital pad, and its 16-bit button word is published.
//
// Ports:
//   CLK, RST        clock; synchronous active-high reset
//   CE              clock enable; sequencing advances only on CE ticks
//   REQ             start scan (accepted in IDLE on a CE tick)
//   ABORT           cancel scan on any CLK edge; beats REQ
//   PORT_EN[1:0]    per-port enable, latched when REQ is accepted
//   P1I/P2I[6:0]    port pins in; [3:0] is the data nibble
//   P1O/P2O[6:0]    port drive; [6]=TH, [5]=TR
//   P1OE/P2OE[6:0]  port output enables; [6:5] follow the latched enable
//   PAD1/PAD2[15:0] published button words (active-low, 16'hFFFF if absent)
//   PRES[1:0]       standard pad present per port
//   BUSY            high outside IDLE
//   DONE            one-CLK pulse when results are published
module smpc_port_scan #(
   parameter int unsigned SETTLE = 8
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        CE,
   input  logic        REQ,
   input  logic        ABORT,
   input  logic [1:0]  PORT_EN,
   input  logic [6:0]  P1I,
   input  logic [6:0]  P2I,
   output logic [6:0]  P1O,
   output logic [6:0]  P1OE,
   output logic [6:0]  P2O,
   output logic [6:0]  P2OE,
   output logic [15:0] PAD1,
   output logic [15:0] PAD2,
   output logic [1:0]  PRES,
   output logic        BUSY,
   output logic        DONE
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_FINISH
   } state_t;

   localparam logic [7:0] RELOAD = 8'(SETTLE - 1);

   state_t      state_q, state_d;
   logic [1:0]  ph_q, ph_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [1:0]  sel_q, sel_d;
   logic [1:0]  en_q, en_d;
   logic [15:0] sh1_q, sh1_d;
   logic [15:0] sh2_q, sh2_d;
   logic [15:0] pad1_q, pad1_d;
   logic [15:0] pad2_q, pad2_d;
   logic [1:0]  pres_q, pres_d;
   logic        done_q, done_d;

   // Only the data nibble of each port is used; the upper pins are ignored.
   logic unused_pins;
   assign unused_pins = ^{P1I[6:4], P2I[6:4]};

   always_comb begin
      state_d = state_q;
      ph_d    = ph_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      en_d    = en_q;
      sh1_d   = sh1_q;
      sh2_d   = sh2_q;
      pad1_d  = pad1_q;
      pad2_d  = pad2_q;
      pres_d  = pres_q;
      done_d  = 1'b0;

      if (ABORT) begin
         // Abort ignores CE and leaves the published results untouched.
         state_d = ST_IDLE;
         sel_d   = 2'b11;
         ph_d    = '0;
         cnt_d   = '0;
      end else if (CE) begin
         case (state_q)
            ST_IDLE: begin
               if (REQ) begin
                  en_d    = PORT_EN;
                  ph_d    = '0;
                  sel_d   = 2'b00;
                  cnt_d   = RELOAD;
                  state_d = ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - 8'd1;
               end else begin
                  // Phase 0 ends up in [15:12], phase 3 in [3:0].
                  sh1_d = {sh1_q[11:0], P1I[3:0]};
                  sh2_d = {sh2_q[11:0], P2I[3:0]};
                  if (ph_q == 2'd3) begin
                     state_d = ST_FINISH;
                  end else begin
                     ph_d  = ph_q + 2'd1;
                     sel_d = ph_q + 2'd1;
                     cnt_d = RELOAD;
                  end
               end
            end
            ST_FINISH: begin
               // sh[2:0] holds the ID bits of the phase-3 nibble.
               if (en_q[0] && (sh1_q[2:0] == 3'b100)) begin
                  pad1_d    = sh1_q;
                  pres_d[0] = 1'b1;
               end else begin
                  pad1_d    = '1;
                  pres_d[0] = 1'b0;
               end
               if (en_q[1] && (sh2_q[2:0] == 3'b100)) begin
                  pad2_d    = sh2_q;
                  pres_d[1] = 1'b1;
               end else begin
                  pad2_d    = '1;
                  pres_d[1] = 1'b0;
               end
               sel_d   = 2'b11;
               ph_d    = '0;
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
               sel_d   = 2'b11;
            end
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
         ph_q    <= '0;
         cnt_q   <= '0;
         sel_q   <= 2'b11;
         en_q    <= '0;
         sh1_q   <= '0;
         sh2_q   <= '0;
         pad1_q  <= '1;
         pad2_q  <= '1;
         pres_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ph_q    <= ph_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         en_q    <= en_d;
         sh1_q   <= sh1_d;
         sh2_q   <= sh2_d;
         pad1_q  <= pad1_d;
         pad2_q  <= pad2_d;
         pres_q  <= pres_d;
         done_q  <= done_d;
      end
   end

   assign P1O  = {sel_q, 5'b0};
   assign P2O  = {sel_q, 5'b0};
   assign P1OE = {{2{en_q[0]}}, 5'b0};
   assign P2OE = {{2{en_q[1]}}, 5'b0};
   assign PAD1 = pad1_q;
   assign PAD2 = pad2_q;
   assign PRES = pres_q;
   assign BUSY = (state_q != ST_IDLE);
   assign DONE = done_q;

endmodule

// File: tb/tb_smpc_port_scan.sv
// Testbench for smpc_port_scan: two instances (SETTLE=8 and SETTLE=2) share
// stimulus. Each port is answered by a pad emulator that returns the nibble
// for whatever select code the DUT drives. The stimulus pushes one expected
// result per accepted scan; a monitor checks timing, select lines and results.
module tb_smpc_port_scan;

   localparam int unsigned SA = 8;
   localparam int unsigned SB = 2;

   typedef struct {
      int unsigned acc;
      logic [1:0]  en;
      logic [15:0] pad1;
      logic [15:0] pad2;
      logic [1:0]  pres;
   } exp_t;

   logic        CLK, RST, CE, REQ, ABORT;
   logic [1:0]  PORT_EN;
   logic [6:0]  p1i[2], p2i[2], p1o[2], p2o[2], p1oe[2], p2oe[2];
   logic [15:0] pad1[2], pad2[2];
   logic [1:0]  pres[2];
   logic        busy[2], done[2];

   logic [3:0]  nib1[4], nib2[4];
   exp_t        sbq0[$], sbq1[$];
   logic [15:0] last_pad1[2], last_pad2[2];
   logic [1:0]  last_pres[2];
   int unsigned tick, cyc, checks, failures;
   logic        ce_mode, mon_en;

   smpc_port_scan #(.SETTLE(SA)) u_dut_a (
      .CLK(CLK), .RST(RST), .CE(CE), .REQ(REQ), .ABORT(ABORT), .PORT_EN(PORT_EN),
      .P1I(p1i[0]), .P2I(p2i[0]), .P1O(p1o[0]), .P1OE(p1oe[0]), .P2O(p2o[0]),
      .P2OE(p2oe[0]), .PAD1(pad1[0]), .PAD2(pad2[0]), .PRES(pres[0]),
      .BUSY(busy[0]), .DONE(done[0])
   );

   smpc_port_scan #(.SETTLE(SB)) u_dut_b (
      .CLK(CLK), .RST(RST), .CE(CE), .REQ(REQ), .ABORT(ABORT), .PORT_EN(PORT_EN),
      .P1I(p1i[1]), .P2I(p2i[1]), .P1O(p1o[1]), .P1OE(p1oe[1]), .P2O(p2o[1]),
      .P2OE(p2oe[1]), .PAD1(pad1[1]), .PAD2(pad2[1]), .PRES(pres[1]),
      .BUSY(busy[1]), .DONE(done[1])
   );

   // Pad emulators: nibble selected by {TH,TR}; upper pins carry junk.
   assign p1i[0] = {3'b101, nib1[p1o[0][6:5]]};
   assign p2i[0] = {3'b110, nib2[p2o[0][6:5]]};
   assign p1i[1] = {3'b101, nib1[p1o[1][6:5]]};
   assign p2i[1] = {3'b110, nib2[p2o[1][6:5]]};

   always #5 CLK = ~CLK;

   always @(posedge CLK) if (CE === 1'b1) tick <= tick + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cycle();
      @(negedge CLK);
      cyc++;
      CE = (ce_mode == 1'b0) || (cyc % 3 == 0);
   endtask

   // Reference: a pad is present when enabled and the phase-3 ID is 100;
   // its word is the four nibbles in phase order, otherwise all ones.
   function automatic exp_t model(input logic [1:0] en, input int unsigned acc);
      exp_t e;
      e.acc  = acc;
      e.en   = en;
      e.pres = {en[1] && (nib2[3][2:0] == 3'b100), en[0] && (nib1[3][2:0] == 3'b100)};
      e.pad1 = e.pres[0] ? {nib1[0], nib1[1], nib1[2], nib1[3]} : 16'hFFFF;
      e.pad2 = e.pres[1] ? {nib2[0], nib2[1], nib2[2], nib2[3]} : 16'hFFFF;
      return e;
   endfunction

   task automatic rand_pads();
      for (int i = 0; i < 4; i++) begin
         nib1[i] = 4'($urandom);
         nib2[i] = 4'($urandom);
      end
      if ($urandom_range(0, 3) != 0) nib1[3][2:0] = 3'b100;
      if ($urandom_range(0, 3) != 0) nib2[3][2:0] = 3'b100;
   endtask

   task automatic start_scan(input logic [1:0] en);
      exp_t e;
      do cycle(); while (!CE);
      REQ = 1'b1;
      PORT_EN = en;
      e = model(en, tick + 1);
      sbq0.push_back(e);
      sbq1.push_back(e);
      cycle();
      REQ = 1'b0;
      PORT_EN = 2'($urandom);
   endtask

   task automatic wait_idle(input int unsigned budget);
      for (int i = 0; i < budget && (sbq0.size() != 0 || sbq1.size() != 0); i++) cycle();
      checks++;
      if (sbq0.size() != 0 || sbq1.size() != 0) begin
         failures++;
         $display("FAIL scan_timeout: pending a=%0d b=%0d expected 0", sbq0.size(), sbq1.size());
         sbq0.delete();
         sbq1.delete();
      end
      cycle();
   endtask

   task automatic do_abort();
      ABORT = 1'b1;
      sbq0.delete();
      sbq1.delete();
      cycle();
      ABORT = 1'b0;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      sbq0.delete();
      sbq1.delete();
      for (int d = 0; d < 2; d++) begin
         last_pad1[d] = 16'hFFFF;
         last_pad2[d] = 16'hFFFF;
         last_pres[d] = 2'b00;
      end
      repeat (2) cycle();
      RST = 1'b0;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rst%0d_p1o", d), p1o[d], 7'h60);
         chk($sformatf("rst%0d_p2o", d), p2o[d], 7'h60);
         chk($sformatf("rst%0d_p1oe", d), p1oe[d], 7'h00);
         chk($sformatf("rst%0d_p2oe", d), p2oe[d], 7'h00);
         chk($sformatf("rst%0d_pad1", d), pad1[d], 16'hFFFF);
         chk($sformatf("rst%0d_pad2", d), pad2[d], 16'hFFFF);
         chk($sformatf("rst%0d_pres", d), pres[d], 2'b00);
         chk($sformatf("rst%0d_busy", d), busy[d], 1'b0);
         chk($sformatf("rst%0d_done", d), done[d], 1'b0);
      end
   endtask

   always begin : monitor
      exp_t e;
      logic have;
      int unsigned s, el, es;
      @(posedge CLK);
      #1;
      if (mon_en) begin
         for (int d = 0; d < 2; d++) begin
            s = (d == 0) ? SA : SB;
            if (d == 0) begin
               have = (sbq0.size() != 0);
               if (have) e = sbq0[0];
            end else begin
               have = (sbq1.size() != 0);
               if (have) e = sbq1[0];
            end
            el = tick - e.acc;
            if (have && el == 4 * s + 1) begin
               chk($sformatf("dut%0d_done", d), done[d], 1'b1);
               chk($sformatf("dut%0d_busy_end", d), busy[d], 1'b0);
               chk($sformatf("dut%0d_pad1", d), pad1[d], e.pad1);
               chk($sformatf("dut%0d_pad2", d), pad2[d], e.pad2);
               chk($sformatf("dut%0d_pres", d), pres[d], e.pres);
               last_pad1[d] = e.pad1;
               last_pad2[d] = e.pad2;
               last_pres[d] = e.pres;
               if (d == 0) void'(sbq0.pop_front());
               else        void'(sbq1.pop_front());
            end else if (have) begin
               es = el / s;
               if (es > 3) es = 3;
               chk($sformatf("dut%0d_done_early", d), done[d], 1'b0);
               chk($sformatf("dut%0d_busy", d), busy[d], 1'b1);
               chk($sformatf("dut%0d_p1o_sel", d), p1o[d], 7'({es[1:0], 5'b0}));
               chk($sformatf("dut%0d_p2o_sel", d), p2o[d], 7'({es[1:0], 5'b0}));
               chk($sformatf("dut%0d_p1oe", d), p1oe[d], e.en[0] ? 7'h60 : 7'h00);
               chk($sformatf("dut%0d_p2oe", d), p2oe[d], e.en[1] ? 7'h60 : 7'h00);
            end else begin
               chk($sformatf("dut%0d_idle_done", d), done[d], 1'b0);
               chk($sformatf("dut%0d_idle_busy", d), busy[d], 1'b0);
               chk($sformatf("dut%0d_idle_p1o", d), p1o[d], 7'h60);
               chk($sformatf("dut%0d_idle_p2o", d), p2o[d], 7'h60);
               chk($sformatf("dut%0d_hold_pad1", d), pad1[d], last_pad1[d]);
               chk($sformatf("dut%0d_hold_pad2", d), pad2[d], last_pad2[d]);
               chk($sformatf("dut%0d_hold_pres", d), pres[d], last_pres[d]);
            end
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation still running, expected finish");
      $fatal(1);
   end

   initial begin
      CLK = 1'b0; RST = 1'b1; CE = 1'b0; REQ = 1'b0; ABORT = 1'b0; PORT_EN = 2'b00;
      ce_mode = 1'b0; mon_en = 1'b0; cyc = 0; tick = 0; checks = 0; failures = 0;
      for (int i = 0; i < 4; i++) begin
         nib1[i] = 4'h0;
         nib2[i] = 4'h0;
      end

      do_reset();
      mon_en = 1'b1;

      // Standard pad on port 1 only.
      nib1 = '{4'hA, 4'h5, 4'hC, 4'h4};
      nib2 = '{4'h1, 4'h2, 4'h3, 4'h4};
      start_scan(2'b01);
      wait_idle(200);
      chk("dir_pad1", pad1[0], 16'hA5C4);
      chk("dir_pres", pres[0], 2'b01);
      chk("dir_pad2", pad2[0], 16'hFFFF);

      // Both enabled, port 2 reports ID 111.
      nib1 = '{4'h3, 4'hF, 4'h0, 4'hC};
      nib2 = '{4'h9, 4'h8, 4'h6, 4'h7};
      start_scan(2'b11);
      wait_idle(200);
      chk("both_pres", pres[0], 2'b01);
      chk("both_pad1", pad1[0], 16'h3F0C);
      chk("both_pad2", pad2[0], 16'hFFFF);

      // Abort ten cycles after the request, then a normal scan.
      rand_pads();
      start_scan(2'b11);
      repeat (9) cycle();
      do_abort();
      chk("abort_busy", busy[0], 1'b0);
      chk("abort_pad1", pad1[0], 16'h3F0C);
      rand_pads();
      start_scan(2'b10);
      wait_idle(200);

      // Sparse CE; a second request while busy must be dropped.
      ce_mode = 1'b1;
      rand_pads();
      start_scan(2'b11);
      repeat (5) cycle();
      do cycle(); while (!CE);
      REQ = 1'b1;
      cycle();
      REQ = 1'b0;
      wait_idle(400);
      repeat (30) cycle();
      ce_mode = 1'b0;

      // Reset in the middle of phase 2.
      rand_pads();
      start_scan(2'b11);
      repeat (18) cycle();
      do_reset();

      // ABORT and REQ together in IDLE: no scan.
      cycle();
      ABORT = 1'b1;
      REQ = 1'b1;
      cycle();
      ABORT = 1'b0;
      REQ = 1'b0;
      repeat (3) cycle();

      for (int n = 0; n < 16; n++) begin
         ce_mode = 1'($urandom_range(0, 1));
         rand_pads();
         start_scan(2'($urandom));
         if ($urandom_range(0, 4) == 0) begin
            repeat ($urandom_range(1, 30)) cycle();
            do_abort();
         end
         wait_idle(500);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
